conv_psum_collector: RTL and testbench

- Consumer end of the convolutional mesh partial-sum interface; sits directly after the PE array.
- Accepts one D-lane row of W-bit partial sums per beat and accumulates them across configured input-channel passes in a local buffer.
- On the final pass, emits completed rows to the output buffer through a valid/ready stream with a 2-entry FIFO.
- Signals done when drained.

---
 rtl/conv_psum_collector.sv | 172 +++++++++++++++++
 tb/tb_conv_psum_collector.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_psum_collector.sv
// Accumulates D-lane partial-sum rows across passes; final-pass rows leave via a 2-entry FIFO one cycle after acceptance.
// psumReady stalls only on the final pass when the FIFO is full; CONV_PSUM_RELU_EN zeroes negative final lanes.
module conv_psum_collector #(
  parameter int depth  = 2,
  parameter int D      = (1 << depth),
  parameter int W      = 16,
  parameter int ADDR_W = 6,
  parameter int PASS_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfgNumRows,
  input  logic [PASS_W-1:0] cfgNumPasses,
  output logic              busy,
  output logic              done,
  input  logic              psumValid,
  output logic              psumReady,
  input  logic [W*D-1:0]    psumIn,
  output logic              outValid,
  input  logic              outReady,
  output logic [W*D-1:0]    outData,
  output logic [ADDR_W-1:0] outIndex
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rows_q, rows_d, row_q, row_d;
  logic [PASS_W-1:0] passes_q, passes_d, pass_q, pass_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              psum_ready_q, psum_ready_d;

  logic [W*D-1:0]    fifo_dat_q [2];
  logic [W*D-1:0]    fifo_dat_d [2];
  logic [ADDR_W-1:0] fifo_idx_q [2];
  logic [ADDR_W-1:0] fifo_idx_d [2];
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic [W*D-1:0]    buf_mem [1 << ADDR_W];
  logic [W*D-1:0]    buf_rd, sum_row, res_row;
  logic              beat, final_pass, last_row, fifo_push, fifo_pop;

  assign final_pass = (pass_q == passes_q);
  assign last_row   = (row_q == rows_q);
  assign beat       = psumValid && psum_ready_q;
  assign fifo_push  = beat && final_pass;
  assign outValid   = (fifo_cnt_q != 2'd0);
  assign fifo_pop   = outValid && outReady;
  assign buf_rd     = buf_mem[row_q];

  assign busy      = busy_q;
  assign done      = done_q;
  assign psumReady = psum_ready_q;
  assign outData   = fifo_dat_q[rd_ptr_q];
  assign outIndex  = fifo_idx_q[rd_ptr_q];

  for (genvar i = 0; i < D; i++) begin : g_lane
    logic signed [W-1:0] in_l, acc_l, sat_l;
    logic signed [W:0]   wide_l;
    assign in_l   = psumIn[W*(i+1)-1 -: W];
    assign acc_l  = buf_rd[W*(i+1)-1 -: W];
    assign wide_l = (pass_q == '0) ? {in_l[W-1], in_l}
                                   : ({acc_l[W-1], acc_l} + {in_l[W-1], in_l});
    // Overflow shows up as the two top bits of the widened sum disagreeing.
    assign sat_l  = (wide_l[W] == wide_l[W-1]) ? wide_l[W-1:0]
                                               : {wide_l[W], {(W-1){~wide_l[W]}}};
    assign sum_row[W*(i+1)-1 -: W] = sat_l;
`ifdef CONV_PSUM_RELU_EN
    assign res_row[W*(i+1)-1 -: W] = sat_l[W-1] ? '0 : sat_l;
`else
    assign res_row[W*(i+1)-1 -: W] = sat_l;
`endif
  end

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    passes_d   = passes_q;
    row_d      = row_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fifo_dat_d = fifo_dat_q;
    fifo_idx_d = fifo_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d   = cfgNumRows;
          passes_d = cfgNumPasses;
          row_d    = '0;
          pass_d   = '0;
          busy_d   = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          if (last_row) begin
            row_d = '0;
            if (final_pass) state_d = DRAIN;
            else            pass_d  = pass_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (fifo_cnt_q == 2'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_push) begin
      fifo_dat_d[wr_ptr_q] = res_row;
      fifo_idx_d[wr_ptr_q] = row_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (fifo_pop) rd_ptr_d = ~rd_ptr_q;
    if (fifo_push && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + 2'd1;
    else if (!fifo_push && fifo_pop) fifo_cnt_d = fifo_cnt_q - 2'd1;

    // Ready is registered, so it is derived from next-cycle state and occupancy.
    psum_ready_d = (state_d == ACCUM) && ((pass_d != passes_d) || (fifo_cnt_d != 2'd2));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      rows_q       <= '0;
      passes_q     <= '0;
      row_q        <= '0;
      pass_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      psum_ready_q <= 1'b0;
      fifo_dat_q   <= '{default: '0};
      fifo_idx_q   <= '{default: '0};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_cnt_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      passes_q     <= passes_d;
      row_q        <= row_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      psum_ready_q <= psum_ready_d;
      fifo_dat_q   <= fifo_dat_d;
      fifo_idx_q   <= fifo_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (beat && !final_pass) buf_mem[row_q] <= sum_row;
  end

endmodule

// File: tb/tb_conv_psum_collector.sv
// Bench for conv_psum_collector: transaction-level model plus directed and randomized jobs.
module tb_conv_psum_collector;
  localparam int DEPTH  = 2;
  localparam int D      = 4;
  localparam int W      = 16;
  localparam int ADDR_W = 6;
  localparam int PASS_W = 4;

  logic              CLK, RST_N, start, busy, done;
  logic [ADDR_W-1:0] cfgNumRows, outIndex;
  logic [PASS_W-1:0] cfgNumPasses;
  logic              psumValid, psumReady, outValid, outReady;
  logic [W*D-1:0]    psumIn, outData;

  conv_psum_collector #(.depth(DEPTH), .D(D), .W(W), .ADDR_W(ADDR_W), .PASS_W(PASS_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .cfgNumRows(cfgNumRows),
    .cfgNumPasses(cfgNumPasses), .busy(busy), .done(done), .psumValid(psumValid),
    .psumReady(psumReady), .psumIn(psumIn), .outValid(outValid), .outReady(outReady),
    .outData(outData), .outIndex(outIndex)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int out_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_of(input logic [W*D-1:0] v, input int l);
    return int'($signed(v[W*l +: W]));
  endfunction

  function automatic logic [W*D-1:0] mk_row(input int a0, input int a1, input int a2, input int a3);
    return {a3[W-1:0], a2[W-1:0], a1[W-1:0], a0[W-1:0]};
  endfunction

  function automatic int rnd_lane();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 200)) - 100;
  endfunction

  function automatic logic [W*D-1:0] rnd_row();
    return mk_row(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
  endfunction

  // Behavioural model: job state, accumulation buffer and expected output stream.
  int m_state;  // 0 idle, 1 accumulating, 2 draining
  int m_rows, m_passes, m_row, m_pass, m_occ;
  bit m_done;
  int m_buf [64][D];
  logic [W*D-1:0] exp_dat_q[$];
  int             exp_idx_q[$];
  logic [W*D-1:0] obs_dat[$];
  int             obs_idx[$];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_state = 0; m_occ = 0; m_done = 0; m_row = 0; m_pass = 0;
      exp_dat_q.delete();
      exp_idx_q.delete();
    end else begin : upd
      bit rdy, bt, pop, fin, last;
      logic [W*D-1:0] vec;
      int s, in;
      fin  = (m_state == 2) && (m_occ == 0);
      rdy  = (m_state == 1) && ((m_pass != m_passes) || (m_occ < 2));
      bt   = psumValid && rdy;
      pop  = (m_occ > 0) && outReady;
      last = (m_pass == m_passes);
      m_done = fin;
      if (pop) begin
        m_occ--;
        void'(exp_dat_q.pop_front());
        void'(exp_idx_q.pop_front());
      end
      if (m_state == 0) begin
        if (start) begin
          m_rows = int'(cfgNumRows); m_passes = int'(cfgNumPasses);
          m_row = 0; m_pass = 0; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (bt) begin
          vec = '0;
          for (int l = 0; l < D; l++) begin
            in = int'($signed(psumIn[W*l +: W]));
            s  = (m_pass == 0) ? in : m_buf[m_row][l] + in;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            if (last) begin
`ifdef CONV_PSUM_RELU_EN
              if (s < 0) s = 0;
`endif
              vec[W*l +: W] = s[W-1:0];
            end else begin
              m_buf[m_row][l] = s;
            end
          end
          if (last) begin
            exp_dat_q.push_back(vec);
            exp_idx_q.push_back(m_row);
            m_occ++;
          end
          if (m_row == m_rows) begin
            m_row = 0;
            if (last) m_state = 2;
            else      m_pass++;
          end else begin
            m_row++;
          end
        end
      end else if (fin) begin
        m_state = 0;
      end
    end
  end

  // Single compare process; outputs are stable at the falling edge.
  always @(negedge CLK) begin
    if (!RST_N) begin
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_psumReady", {63'd0, psumReady}, 64'd0);
      chk("rst_outValid", {63'd0, outValid}, 64'd0);
      chk("rst_outIndex", {58'd0, outIndex}, 64'd0);
    end else begin
      chk("busy", {63'd0, busy}, {63'd0, m_state != 0});
      chk("done", {63'd0, done}, {63'd0, m_done});
      chk("psumReady", {63'd0, psumReady},
          {63'd0, (m_state == 1) && ((m_pass != m_passes) || (m_occ < 2))});
      chk("outValid", {63'd0, outValid}, {63'd0, m_occ > 0});
      if (m_occ > 0 && exp_dat_q.size() > 0) begin
        chk("outData", outData, exp_dat_q[0]);
        chk("outIndex", {58'd0, outIndex}, 64'(exp_idx_q[0]));
      end
      if (outValid && outReady) begin
        obs_dat.push_back(outData);
        obs_idx.push_back(int'(outIndex));
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    case (out_mode)
      0:       outReady = 1'b1;
      1:       outReady = ($urandom_range(0, 2) != 0);
      default: outReady = 1'b0;
    endcase
  end

  // Tasks are entered and left at a falling edge.
  task automatic start_job(input int rows, input int passes);
    start = 1'b1;
    cfgNumRows = rows[ADDR_W-1:0];
    cfgNumPasses = passes[PASS_W-1:0];
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_row(input logic [W*D-1:0] dat);
    int t = 0;
    psumValid = 1'b1;
    psumIn = dat;
    while (!psumReady && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (!psumReady) chk("send_timeout", 64'(t), 64'd0);
    @(negedge CLK);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    psumValid = 1'b0;
    while (!done && t < 500) begin
      @(negedge CLK);
      t++;
    end
    chk(name, {63'd0, done}, 64'd1);
    @(negedge CLK);
  endtask

  task automatic scenario_pass_through(input string tag);
    obs_dat.delete(); obs_idx.delete();
    out_mode = 0;
    start_job(3, 0);
    for (int k = 0; k < 4; k++) send_row(mk_row(k + 1, 0, 0, 0));
    wait_done({tag, "_done"});
    chk({tag, "_count"}, 64'(obs_dat.size()), 64'd4);
    for (int k = 0; k < 4 && k < obs_dat.size(); k++) begin
      chk({tag, "_lane0"}, 64'(lane_of(obs_dat[k], 0)), 64'(k + 1));
      chk({tag, "_idx"}, 64'(obs_idx[k]), 64'(k));
    end
  endtask

  initial begin
    int k, t, nrows, npass, exp1;
    RST_N = 1'b1; start = 1'b0; psumValid = 1'b0; psumIn = '0;
    cfgNumRows = '0; cfgNumPasses = '0; outReady = 1'b0;
    #1 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_outValid", {63'd0, outValid}, 64'd0);
    chk("reset_outData", outData, 64'd0);

    scenario_pass_through("s1");

    // Three passes of constant 5 accumulate to 15.
    obs_dat.delete(); obs_idx.delete();
    start_job(1, 2);
    for (int b = 0; b < 6; b++) send_row(mk_row(5, 5, 5, 5));
    wait_done("s2_done");
    chk("s2_count", 64'(obs_dat.size()), 64'd2);
    for (int r = 0; r < 2 && r < obs_dat.size(); r++) begin
      for (int l = 0; l < D; l++) chk("s2_lane", 64'(lane_of(obs_dat[r], l)), 64'd15);
      chk("s2_idx", 64'(obs_idx[r]), 64'(r));
    end

    // Saturation at both rails.
    obs_dat.delete(); obs_idx.delete();
    start_job(0, 1);
    send_row(mk_row(30000, -30000, 7, 0));
    send_row(mk_row(10000, -10000, -9, 0));
    wait_done("s3_done");
    chk("s3_count", 64'(obs_dat.size()), 64'd1);
`ifdef CONV_PSUM_RELU_EN
    exp1 = 0;
`else
    exp1 = -32768;
`endif
    if (obs_dat.size() > 0) begin
      chk("s3_lane0", 64'(lane_of(obs_dat[0], 0)), 64'd32767);
      chk("s3_lane1", 64'(lane_of(obs_dat[0], 1)), 64'(exp1));
    end

    // Final-pass backpressure: only two rows fit while the output stalls.
    obs_dat.delete(); obs_idx.delete();
    out_mode = 2;
    @(negedge CLK);
    start_job(3, 0);
    k = 0;
    psumValid = 1'b1;
    psumIn = mk_row(100, -1, 0, 0);
    repeat (10) begin
      if (psumReady && psumValid) k++;
      @(negedge CLK);
      if (k < 4) psumIn = mk_row(100 + k, -1 - k, k, 0);
      else psumValid = 1'b0;
    end
    chk("s4_accepted_stalled", 64'(k), 64'd2);
    out_mode = 0;
    t = 0;
    while (k < 4 && t < 100) begin
      if (psumReady && psumValid) k++;
      @(negedge CLK);
      t++;
      if (k < 4) psumIn = mk_row(100 + k, -1 - k, k, 0);
      else psumValid = 1'b0;
    end
    wait_done("s4_done");
    chk("s4_count", 64'(obs_dat.size()), 64'd4);
    for (int r = 0; r < 4 && r < obs_dat.size(); r++) begin
      chk("s4_lane0", 64'(lane_of(obs_dat[r], 0)), 64'(100 + r));
      chk("s4_idx", 64'(obs_idx[r]), 64'(r));
    end

    // Start while busy must not disturb the running job.
    obs_dat.delete(); obs_idx.delete();
    start_job(3, 1);
    for (int b = 0; b < 8; b++) begin
      if (b == 3) begin
        start = 1'b1; cfgNumRows = 6'd10; cfgNumPasses = 4'd3;
      end
      send_row(rnd_row());
      start = 1'b0;
    end
    wait_done("s5_done");
    chk("s5_count", 64'(obs_dat.size()), 64'd4);

    // Reset mid-job with one entry queued.
    out_mode = 2;
    @(negedge CLK);
    start_job(3, 0);
    send_row(mk_row(42, 0, 0, 0));
    psumValid = 1'b0;
    chk("s6_fifo_one", {63'd0, outValid}, 64'd1);
    #1 RST_N = 1'b0;
    #1;
    chk("s6_outValid", {63'd0, outValid}, 64'd0);
    chk("s6_busy", {63'd0, busy}, 64'd0);
    chk("s6_psumReady", {63'd0, psumReady}, 64'd0);
    @(negedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    scenario_pass_through("s6_after");

    // Randomized jobs with random gaps, backpressure and ignored starts.
    out_mode = 1;
    for (int j = 0; j < 8; j++) begin
      obs_dat.delete(); obs_idx.delete();
      nrows = $urandom_range(0, 7);
      npass = $urandom_range(0, 3);
      start_job(nrows, npass);
      for (int b = 0; b < (nrows + 1) * (npass + 1); b++) begin
        if ($urandom_range(0, 3) == 0) begin
          psumValid = 1'b0;
          @(negedge CLK);
        end
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1;
          cfgNumRows = 6'($urandom_range(0, 63));
          cfgNumPasses = 4'($urandom_range(0, 15));
        end
        send_row(rnd_row());
        start = 1'b0;
      end
      wait_done("rnd_done");
      chk("rnd_count", 64'(obs_dat.size()), 64'(nrows + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
